// File: rtl/ingress_tlp_decoder.sv
// Ingress TLP decoder: turns single-DW MemRd/MemWr TLPs from the PCIe RX AXI-stream into
// register write strobes and held read requests; anything else is dropped with err_pulse.
module ingress_tlp_decoder #(
   parameter int         CHNL_NUM     = 12,
   parameter int         CHNL_W       = 4,
   parameter logic [6:0] BAR_HIT_MASK = 7'b0000001
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [63:0]       s_axis_rx_tdata,
   input  logic [7:0]        s_axis_rx_tkeep,
   input  logic              s_axis_rx_tlast,
   input  logic              s_axis_rx_tvalid,
   input  logic [21:0]       s_axis_rx_tuser,
   output logic              s_axis_rx_tready,
   output logic              reg_wr_en,
   output logic [CHNL_W-1:0] reg_wr_chnl,
   output logic [3:0]        reg_wr_off,
   output logic [31:0]       reg_wr_data,
   output logic              rd_req_valid,
   input  logic              rd_req_ready,
   output logic [CHNL_W-1:0] rd_req_chnl,
   output logic [3:0]        rd_req_off,
   output logic              rd_req_bad,
   output logic [15:0]       rd_req_rid,
   output logic [7:0]        rd_req_tag,
   output logic [2:0]        rd_req_tc,
   output logic [1:0]        rd_req_attr,
   output logic [6:0]        rd_req_laddr,
   output logic              err_pulse
);

   typedef enum logic [2:0] {IDLE, HDR2, DATA3, RD_HOLD, DISCARD} state_t;

   localparam logic [CHNL_W:0] CHNL_LIM = (CHNL_W+1)'(CHNL_NUM);

   state_t            state_q;
   logic              is4dw_q, iswr_q;
   logic [3:0]        fbe_q;
   logic [15:0]       rid_q;
   logic [7:0]        tag_q;
   logic [2:0]        tc_q;
   logic [1:0]        attr_q;
   logic [CHNL_W-1:0] chnl_q;
   logic [3:0]        off_q;

   logic              acc, hdr_ok, chnl_ok, wr_ok, rd_bad;
   logic [31:0]       addr, w_data;
   logic [CHNL_W-1:0] w_chnl;
   logic [3:0]        w_off;
   logic              unused_ok;

   assign acc    = s_axis_rx_tvalid & s_axis_rx_tready;
   // type 0 covers MemRd/MemWr in every fmt; fmt then only selects 3DW/4DW and rd/wr
   assign hdr_ok = (s_axis_rx_tdata[28:24] == 5'd0) && (s_axis_rx_tdata[9:0] == 10'd1) &&
                   ((s_axis_rx_tuser[8:2] & BAR_HIT_MASK) != 7'd0);
   assign addr   = is4dw_q ? s_axis_rx_tdata[63:32] : s_axis_rx_tdata[31:0];
   assign w_chnl = (state_q == DATA3) ? chnl_q : addr[6+CHNL_W-1:6];
   assign w_off  = (state_q == DATA3) ? off_q : addr[5:2];
   assign w_data = (state_q == DATA3) ? s_axis_rx_tdata[31:0] : s_axis_rx_tdata[63:32];
   assign chnl_ok = {1'b0, w_chnl} < CHNL_LIM;
   assign wr_ok   = chnl_ok && !w_off[3] && (fbe_q != 4'd0);
   // read "bad" marks out-of-range channels and every offset in the 0..7 window
   assign rd_bad  = !chnl_ok || !w_off[3];

   assign unused_ok = ^{s_axis_rx_tkeep, s_axis_rx_tuser[21:9], s_axis_rx_tuser[1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         is4dw_q          <= 1'b0;
         iswr_q           <= 1'b0;
         fbe_q            <= '0;
         rid_q            <= '0;
         tag_q            <= '0;
         tc_q             <= '0;
         attr_q           <= '0;
         chnl_q           <= '0;
         off_q            <= '0;
         s_axis_rx_tready <= 1'b0;
         reg_wr_en        <= 1'b0;
         reg_wr_chnl      <= '0;
         reg_wr_off       <= '0;
         reg_wr_data      <= '0;
         rd_req_valid     <= 1'b0;
         rd_req_chnl      <= '0;
         rd_req_off       <= '0;
         rd_req_bad       <= 1'b0;
         rd_req_rid       <= '0;
         rd_req_tag       <= '0;
         rd_req_tc        <= '0;
         rd_req_attr      <= '0;
         rd_req_laddr     <= '0;
         err_pulse        <= 1'b0;
      end else begin
         reg_wr_en        <= 1'b0;
         err_pulse        <= 1'b0;
         s_axis_rx_tready <= 1'b1;
         case (state_q)
            IDLE: if (acc) begin
               iswr_q  <= s_axis_rx_tdata[30];
               is4dw_q <= s_axis_rx_tdata[29];
               tc_q    <= s_axis_rx_tdata[22:20];
               attr_q  <= s_axis_rx_tdata[13:12];
               fbe_q   <= s_axis_rx_tdata[35:32];
               tag_q   <= s_axis_rx_tdata[47:40];
               rid_q   <= s_axis_rx_tdata[63:48];
               if (s_axis_rx_tlast)  err_pulse <= 1'b1;
               else if (!hdr_ok)     state_q   <= DISCARD;
               else                  state_q   <= HDR2;
            end
            HDR2: if (acc) begin
               if (iswr_q && is4dw_q) begin
                  if (s_axis_rx_tlast) begin
                     err_pulse <= 1'b1;
                     state_q   <= IDLE;
                  end else begin
                     chnl_q  <= w_chnl;
                     off_q   <= w_off;
                     state_q <= DATA3;
                  end
               end else if (!s_axis_rx_tlast) begin
                  state_q <= DISCARD;
               end else if (iswr_q) begin
                  if (wr_ok) begin
                     reg_wr_en   <= 1'b1;
                     reg_wr_chnl <= w_chnl;
                     reg_wr_off  <= w_off;
                     reg_wr_data <= w_data;
                  end else begin
                     err_pulse <= 1'b1;
                  end
                  state_q <= IDLE;
               end else begin
                  rd_req_valid     <= 1'b1;
                  rd_req_chnl      <= w_chnl;
                  rd_req_off       <= w_off;
                  rd_req_bad       <= rd_bad;
                  rd_req_rid       <= rid_q;
                  rd_req_tag       <= tag_q;
                  rd_req_tc        <= tc_q;
                  rd_req_attr      <= attr_q;
                  rd_req_laddr     <= addr[6:0];
                  s_axis_rx_tready <= 1'b0;
                  state_q          <= RD_HOLD;
               end
            end
            DATA3: if (acc) begin
               if (s_axis_rx_tlast) begin
                  if (wr_ok) begin
                     reg_wr_en   <= 1'b1;
                     reg_wr_chnl <= w_chnl;
                     reg_wr_off  <= w_off;
                     reg_wr_data <= w_data;
                  end else begin
                     err_pulse <= 1'b1;
                  end
                  state_q <= IDLE;
               end else begin
                  state_q <= DISCARD;
               end
            end
            RD_HOLD: begin
               // rd_req_valid is always high here, so ready alone completes the handshake
               if (rd_req_ready) begin
                  rd_req_valid <= 1'b0;
                  state_q      <= IDLE;
               end else begin
                  s_axis_rx_tready <= 1'b0;
               end
            end
            DISCARD: if (acc && s_axis_rx_tlast) begin
               err_pulse <= 1'b1;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ingress_tlp_decoder.sv
// Bench for ingress_tlp_decoder: directed TLPs, a transaction-level outcome model with
// an ordered event queue, and a per-cycle monitor comparing DUT strobes/requests to it.
module tb_ingress_tlp_decoder;
   localparam int         CHNL_NUM = 4;
   localparam logic [6:0] MASK     = 7'b0000001;
   localparam int EV_WR = 0, EV_RD = 1, EV_ERR = 2;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [63:0] tdata = '0;
   logic [7:0]  tkeep = 8'hFF;
   logic        tlast = 1'b0, tvalid = 1'b0;
   logic [21:0] tuser = '0;
   logic        tready, wr_en, rd_valid, rd_ready = 1'b1, rd_bad, err;
   logic [3:0]  wr_chnl, wr_off, rd_chnl, rd_off;
   logic [31:0] wr_data;
   logic [15:0] rd_rid;
   logic [7:0]  rd_tag;
   logic [2:0]  rd_tc;
   logic [1:0]  rd_attr;
   logic [6:0]  rd_laddr;

   ingress_tlp_decoder #(.CHNL_NUM(CHNL_NUM), .CHNL_W(4), .BAR_HIT_MASK(MASK)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_rx_tdata(tdata), .s_axis_rx_tkeep(tkeep), .s_axis_rx_tlast(tlast),
      .s_axis_rx_tvalid(tvalid), .s_axis_rx_tuser(tuser), .s_axis_rx_tready(tready),
      .reg_wr_en(wr_en), .reg_wr_chnl(wr_chnl), .reg_wr_off(wr_off), .reg_wr_data(wr_data),
      .rd_req_valid(rd_valid), .rd_req_ready(rd_ready), .rd_req_chnl(rd_chnl),
      .rd_req_off(rd_off), .rd_req_bad(rd_bad), .rd_req_rid(rd_rid), .rd_req_tag(rd_tag),
      .rd_req_tc(rd_tc), .rd_req_attr(rd_attr), .rd_req_laddr(rd_laddr), .err_pulse(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind; logic [3:0] chnl; logic [3:0] off; logic [31:0] data; logic bad;
      logic [15:0] rid; logic [7:0] tag; logic [2:0] tc; logic [1:0] attr; logic [6:0] laddr;
   } ev_t;
   typedef struct {
      logic [1:0] fmt; logic [4:0] typ; logic [9:0] len; logic [6:0] bar; logic [63:0] addr;
      logic [31:0] data; logic [3:0] be; logic [15:0] rid; logic [7:0] tag; logic [2:0] tc;
      logic [1:0] attr; int nbeats;
   } tlp_t;

   ev_t expq[$];
   int  wr_cycles[$];
   int  checks = 0, fails = 0, cyc = 0, stalls = 0;
   ev_t last_wr;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic tlp_t mk(logic [1:0] fmt, logic [63:0] addr, logic [31:0] data, int nb);
      tlp_t t;
      t.fmt = fmt; t.typ = 5'd0; t.len = 10'd1; t.bar = 7'b0000001; t.addr = addr;
      t.data = data; t.be = 4'hF; t.rid = 16'h0100; t.tag = 8'h01; t.tc = 3'd0;
      t.attr = 2'd0; t.nbeats = nb;
      return t;
   endfunction

   // Outcome of one TLP from its header, payload size and number of beats actually sent.
   function automatic ev_t model(tlp_t t);
      ev_t e;
      int  need, ch, of;
      e = '{default: 0};
      e.kind = EV_ERR;
      need = ((t.fmt[0] ? 4 : 3) + (t.fmt[1] ? 1 : 0) + 1) / 2;
      if (t.typ != 0 || t.len != 1 || (t.bar & MASK) == 0 || t.nbeats != need) return e;
      ch = int'(t.addr[9:6]);
      of = int'(t.addr[5:2]);
      if (t.fmt[1]) begin
         if (ch < CHNL_NUM && of <= 7 && t.be != 0) begin
            e.kind = EV_WR; e.chnl = 4'(ch); e.off = 4'(of); e.data = t.data;
         end
      end else begin
         e.kind = EV_RD; e.chnl = 4'(ch); e.off = 4'(of);
         e.bad = (ch >= CHNL_NUM) || (of <= 7);
         e.rid = t.rid; e.tag = t.tag; e.tc = t.tc; e.attr = t.attr; e.laddr = t.addr[6:0];
      end
      return e;
   endfunction

   function automatic logic [63:0] beat_of(tlp_t t, int i);
      logic [31:0] dw0, dw1;
      dw0 = {1'b0, t.fmt, t.typ, 1'b0, t.tc, 4'b0, 2'b0, t.attr, 2'b0, t.len};
      dw1 = {t.rid, t.tag, 4'b0, t.be};
      if (i == 0) return {dw1, dw0};
      if (t.fmt[0]) begin
         if (i == 1) return {t.addr[31:0], t.addr[63:32]};
         if (i == 2) return {32'h0, t.data};
      end else if (i == 1) begin
         return {t.data, t.addr[31:0]};
      end
      return 64'h5A5A_0000_0000_0000 | 64'(i);
   endfunction

   // Called just after a negedge; tready cannot change before the next posedge.
   task automatic drive_beat(logic [63:0] d, logic last, logic [6:0] bar);
      int n = 0;
      tdata = d; tlast = last; tvalid = 1'b1; tuser = {13'd0, bar, 2'b00};
      while (!tready && n < 64) begin
         @(negedge clk);
         n++; stalls++;
      end
      if (n >= 64) chk("beat_accept_timeout", 64'(tready), 64'd1);
      @(negedge clk);
   endtask

   task automatic send(tlp_t t, bit cont);
      expq.push_back(model(t));
      for (int i = 0; i < t.nbeats; i++) drive_beat(beat_of(t, i), (i == t.nbeats - 1), t.bar);
      if (!cont) begin tvalid = 1'b0; tlast = 1'b0; end
   endtask

   task automatic idle(int n);
      tvalid = 1'b0; tlast = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Monitor: samples 1ns after each posedge, uses previous sample to detect handshakes.
   initial begin
      logic p_valid;
      ev_t  p, e;
      p_valid = 1'b0;
      p = '{default: 0};
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (!rst_n) begin
            p_valid = 1'b0;
         end else begin
            if (wr_en) begin
               wr_cycles.push_back(cyc);
               last_wr.chnl = wr_chnl; last_wr.off = wr_off; last_wr.data = wr_data;
               if (expq.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
               else begin
                  e = expq.pop_front();
                  chk("wr_kind", 64'(EV_WR), 64'(e.kind));
                  chk("wr_fields", {wr_chnl, wr_off, wr_data}, {e.chnl, e.off, e.data});
               end
            end
            if (err) begin
               if (expq.size() == 0) chk("unexpected_err", 64'd1, 64'd0);
               else begin
                  e = expq.pop_front();
                  chk("err_kind", 64'(EV_ERR), 64'(e.kind));
               end
            end
            if (p_valid && rd_ready) begin
               if (expq.size() == 0) chk("unexpected_read", 64'd1, 64'd0);
               else begin
                  e = expq.pop_front();
                  chk("rd_kind", 64'(EV_RD), 64'(e.kind));
                  chk("rd_target", {p.chnl, p.off, p.bad, p.laddr}, {e.chnl, e.off, e.bad, e.laddr});
                  chk("rd_ids", {p.rid, p.tag, p.tc, p.attr}, {e.rid, e.tag, e.tc, e.attr});
               end
            end else if (p_valid) begin
               chk("rd_valid_held", 64'(rd_valid), 64'd1);
               chk("rd_fields_stable",
                   {rd_chnl, rd_off, rd_bad, rd_rid, rd_tag, rd_tc, rd_attr, rd_laddr},
                   {p.chnl, p.off, p.bad, p.rid, p.tag, p.tc, p.attr, p.laddr});
            end
            if (rd_valid) chk("tready_low_in_hold", 64'(tready), 64'd0);
            p_valid = rd_valid;
            p.chnl = rd_chnl; p.off = rd_off; p.bad = rd_bad; p.rid = rd_rid; p.tag = rd_tag;
            p.tc = rd_tc; p.attr = rd_attr; p.laddr = rd_laddr;
         end
      end
   end

   initial begin
      tlp_t t;
      ev_t  m;
      int   n;
      @(negedge clk);
      @(negedge clk);
      chk("rst_tready", 64'(tready), 64'd0);
      chk("rst_outputs", {wr_en, rd_valid, err, rd_bad, wr_data, rd_rid}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("tready_after_release", 64'(tready), 64'd1);

      // 3DW MemWr to 0x44
      t = mk(2'b10, 64'h44, 32'hDEADBEEF, 2);
      m = model(t);
      chk("model_wr44", {32'(m.kind), m.chnl, m.off, m.data}, {32'(EV_WR), 4'd1, 4'd1, 32'hDEADBEEF});
      send(t, 0);
      idle(3);
      chk("wr44_dut", {last_wr.chnl, last_wr.off, last_wr.data}, {4'd1, 4'd1, 32'hDEADBEEF});

      // 4DW MemRd held for 5 cycles by rd_req_ready
      rd_ready = 1'b0;
      t = mk(2'b01, 64'h1_0000_0280, 32'h0, 2);
      t.tag = 8'h2A; t.rid = 16'h0100;
      m = model(t);
      chk("model_rd280", {m.chnl, m.off, m.bad, m.laddr}, {4'd10, 4'd0, 1'b1, 7'h00});
      send(t, 0);
      for (int i = 0; i < 5; i++) begin
         chk("rd280_hold", {rd_valid, tready}, 2'b10);
         @(negedge clk);
      end
      chk("rd280_fields", {rd_chnl, rd_off, rd_bad, rd_laddr, rd_tag, rd_rid},
          {4'd10, 4'd0, 1'b1, 7'h00, 8'h2A, 16'h0100});
      rd_ready = 1'b1;
      @(negedge clk);
      chk("rd280_release", {rd_valid, tready}, 2'b01);

      // 3DW MemRd, offset above 7 in a valid channel, with tc/attr
      t = mk(2'b00, 64'hA4, 32'h0, 2);
      t.rid = 16'hABCD; t.tag = 8'h55; t.tc = 3'd3; t.attr = 2'd2;
      m = model(t);
      chk("model_rdA4", {m.chnl, m.off, m.bad}, {4'd2, 4'd9, 1'b0});
      send(t, 1);
      // write into a channel >= CHNL_NUM, straight after the read
      t = mk(2'b10, 64'h148, 32'h1111_2222, 2);
      m = model(t);
      chk("model_chnl5", 64'(m.kind), 64'(EV_ERR));
      send(t, 0);
      idle(3);

      // drops: too many beats, then a normal write back-to-back
      t = mk(2'b10, 64'h44, 32'h0, 3); t.len = 10'd2;
      send(t, 1);
      send(mk(2'b10, 64'hDC, 32'h1234_5678, 2), 0);
      idle(3);
      chk("after_discard_wr", {last_wr.chnl, last_wr.off, last_wr.data}, {4'd3, 4'd7, 32'h12345678});
      send(mk(2'b11, 64'h8C, 32'h0, 2), 1);                 // 4DW MemWr ending early
      send(mk(2'b10, 64'h44, 32'h0, 1), 1);                 // tlast on first beat
      t = mk(2'b00, 64'h44, 32'h0, 2); t.typ = 5'd4; send(t, 1);      // unsupported type
      t = mk(2'b10, 64'h44, 32'h0, 2); t.bar = 7'b0000010; send(t, 1); // BAR outside mask
      t = mk(2'b10, 64'h44, 32'h0, 2); t.be = 4'h0; send(t, 1);        // first_be zero
      send(mk(2'b10, 64'h64, 32'h0, 2), 1);                 // offset 9 write
      send(mk(2'b00, 64'h44, 32'h0, 3), 0);                 // MemRd with extra beat
      idle(4);

      // reset during beat 2 of a 4DW MemWr
      t = mk(2'b11, 64'h8C, 32'hBADBAD00, 3);
      drive_beat(beat_of(t, 0), 1'b0, t.bar);
      tdata = beat_of(t, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_outputs", {wr_en, err, rd_valid, tready, wr_data}, 36'd0);
      tvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(mk(2'b11, 64'h8C, 32'hCAFEF00D, 3), 0);
      idle(3);
      chk("after_reset_wr", {last_wr.chnl, last_wr.off, last_wr.data}, {4'd2, 4'd3, 32'hCAFEF00D});

      // ten back-to-back 3DW writes
      stalls = 0;
      wr_cycles.delete();
      for (int i = 0; i < 10; i++)
         send(mk(2'b10, 64'(((i % 4) << 6) | ((i % 8) << 2)), 32'h1111_1111 * i, 2), i != 9);
      idle(4);
      chk("b2b_count", 64'(wr_cycles.size()), 64'd10);
      chk("b2b_stalls", 64'(stalls), 64'd0);
      for (int i = 1; i < wr_cycles.size(); i++)
         chk("b2b_gap", 64'(wr_cycles[i] - wr_cycles[i-1]), 64'd2);

      n = 0;
      while (expq.size() != 0 && n < 20) begin @(negedge clk); n++; end
      chk("events_drained", 64'(expq.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
